// File: rtl/vend_if.sv
// vend_if: coin/cancel inputs and credit/eject/dispense outputs of the vending sequencer
interface vend_if #(parameter int CW = 9);
  logic n_s, di_s, q_s, do_s, cancel;
  logic [CW-1:0] credit;
  logic dispense, ret_n, ret_d, ret_q, coin_rej, busy;
  modport master(output n_s, di_s, q_s, do_s, cancel,
                 input credit, dispense, ret_n, ret_d, ret_q, coin_rej, busy);
  modport slave(input n_s, di_s, q_s, do_s, cancel,
                output credit, dispense, ret_n, ret_d, ret_q, coin_rej, busy);
endinterface

// File: rtl/vend_ctrl.sv
// vend_ctrl: accumulates coin credit, dispenses at PRICE, pays change as eject/gap pulses
module vend_ctrl #(
  parameter int PRICE = 125,
  parameter int CREDIT_MAX = 300,
  parameter int CW = 9
) (
  input logic clk,
  input logic rst,
  vend_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_e;
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] MAX_C = CW'(CREDIT_MAX);
  localparam logic [CW-1:0] C5 = CW'(5);
  localparam logic [CW-1:0] C10 = CW'(10);
  localparam logic [CW-1:0] C25 = CW'(25);
  localparam logic [CW-1:0] C100 = CW'(100);
  state_e state_q, state_d;
  logic [CW-1:0] credit_q, credit_d, sum, coin_d;
  logic ej_q, ej_d, rej_d;
  logic dispense_q, ret_n_q, ret_d_q, ret_q_q, coin_rej_q, busy_q;
  function automatic logic [CW-1:0] pick(input logic [CW-1:0] c);
    return c >= C25 ? C25 : c >= C10 ? C10 : C5;
  endfunction
  assign sum = (bus.n_s ? C5 : '0) + (bus.di_s ? C10 : '0) + (bus.q_s ? C25 : '0) + (bus.do_s ? C100 : '0);
  assign coin_d = pick(credit_d);
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    ej_d = 1'b0;
    rej_d = 1'b0;
    unique case (state_q)
      IDLE, COLLECT: begin
        if (sum != '0) begin
          if (credit_q + sum <= MAX_C) credit_d = credit_q + sum;
          else rej_d = 1'b1;
        end
        if (bus.cancel && credit_d != '0) begin
          state_d = CHANGE;
          ej_d = 1'b1;
        end else begin
          state_d = credit_d >= PRICE_C ? VEND : credit_d != '0 ? COLLECT : IDLE;
        end
      end
      VEND: begin
        rej_d = sum != '0;
        credit_d = credit_q - PRICE_C;
        state_d = credit_d != '0 ? CHANGE : IDLE;
        ej_d = 1'b1;
      end
      CHANGE: begin
        rej_d = sum != '0;
        // eject cycle pays the coin announced on entry; gap cycle re-arms the next eject
        credit_d = ej_q ? credit_q - pick(credit_q) : credit_q;
        state_d = credit_d == '0 ? IDLE : CHANGE;
        ej_d = !ej_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      credit_q <= '0;
      ej_q <= 1'b0;
      dispense_q <= 1'b0;
      ret_n_q <= 1'b0;
      ret_d_q <= 1'b0;
      ret_q_q <= 1'b0;
      coin_rej_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      ej_q <= ej_d;
      dispense_q <= state_d == VEND;
      ret_n_q <= state_d == CHANGE && ej_d && coin_d == C5;
      ret_d_q <= state_d == CHANGE && ej_d && coin_d == C10;
      ret_q_q <= state_d == CHANGE && ej_d && coin_d == C25;
      coin_rej_q <= rej_d;
      busy_q <= state_d == VEND || state_d == CHANGE;
    end
  end
  assign bus.credit = credit_q;
  assign bus.dispense = dispense_q;
  assign bus.ret_n = ret_n_q;
  assign bus.ret_d = ret_d_q;
  assign bus.ret_q = ret_q_q;
  assign bus.coin_rej = coin_rej_q;
  assign bus.busy = busy_q;
endmodule
